// File: rtl/rgbw_pwm_engine.sv
`default_nettype none
// ============================================================================
// Module   : rgbw_pwm_engine
// Purpose  : Four-channel (R/G/B/W) PWM generator. Advances on the shared
//            divided-clock enable, double-buffers duty values so a new set of
//            duties only takes effect on a PWM period boundary, and staggers
//            the four channel counters to spread LED switching inrush.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous active-low reset
//            clk_half     - one-cycle tick enable from the clock divider
//            load         - one-cycle strobe capturing duty0..duty3
//            duty0..3     - 8-bit duties (0 = off, >= TOP+1 = always on)
//            d0..d3       - registered PWM outputs (red/green/blue/white)
//            pending      - loaded duties waiting for a period boundary
//            upd_ack      - pulse in the cycle the shadow duties update
//            period_start - pulse when channel 0 wraps TOP -> 0
// Params   : TOP        - last counter value, period = TOP+1 ticks
//            PHASE_STEP - channel i counter starts at i*PHASE_STEP;
//                         must satisfy 3*PHASE_STEP <= TOP <= 255
// Revision : 1.0 - initial release
// ============================================================================
module rgbw_pwm_engine #(
  parameter int unsigned TOP        = 254,
  parameter int unsigned PHASE_STEP = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_half,
  input  logic       load,
  input  logic [7:0] duty0,
  input  logic [7:0] duty1,
  input  logic [7:0] duty2,
  input  logic [7:0] duty3,
  output logic       d0,
  output logic       d1,
  output logic       d2,
  output logic       d3,
  output logic       pending,
  output logic       upd_ack,
  output logic       period_start
);

  localparam logic [7:0] C_TOP = 8'(TOP);

  // --------------------------------------------------------------------------
  // Shared control state
  // --------------------------------------------------------------------------
  logic       pending_q,      pending_d;
  logic       upd_ack_q,      upd_ack_d;
  logic       period_start_q, period_start_d;

  logic       wrap;         // channel 0 wraps on this edge
  logic       apply;        // shadow registers take pend values on this edge
  logic [7:0] cnt0_now;     // channel 0 counter, reference for the period

  logic [7:0] duty_in [4];
  logic [3:0] d_vec;

  assign duty_in[0] = duty0;
  assign duty_in[1] = duty1;
  assign duty_in[2] = duty2;
  assign duty_in[3] = duty3;

  assign wrap  = clk_half && (cnt0_now == C_TOP);
  assign apply = wrap && pending_q;

  always_comb begin
    pending_d      = pending_q;
    upd_ack_d      = apply;
    period_start_d = wrap;
    if (apply) begin
      pending_d = 1'b0;
    end
    // A load in the wrap cycle lands in pend after the current pend has been
    // promoted to shadow, so it must stay pending for the next boundary.
    if (load) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q      <= 1'b0;
      upd_ack_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      upd_ack_q      <= upd_ack_d;
      period_start_q <= period_start_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel counter, pend/shadow duty buffers and compare output
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < 4; i++) begin : g_chan
    // Each channel counter starts offset so the rising edges of the four
    // outputs are spread across the period instead of coinciding.
    localparam logic [7:0] C_CNT_RST = 8'(i * PHASE_STEP);

    logic [7:0] cnt_q,    cnt_d;
    logic [7:0] pend_q,   pend_d;
    logic [7:0] shadow_q, shadow_d;
    logic       pwm_q,    pwm_d;

    always_comb begin
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      shadow_d = shadow_q;
      // Compare uses the pre-edge counter, so the output lags it by a clock.
      // A duty above TOP can never be reached by the counter: constant high.
      pwm_d    = (cnt_q < shadow_q);
      if (clk_half) begin
        cnt_d = (cnt_q == C_TOP) ? 8'd0 : cnt_q + 8'd1;
      end
      if (load) begin
        pend_d = duty_in[i];
      end
      if (apply) begin
        shadow_d = pend_q;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_q    <= C_CNT_RST;
        pend_q   <= 8'd0;
        shadow_q <= 8'd0;
        pwm_q    <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        pend_q   <= pend_d;
        shadow_q <= shadow_d;
        pwm_q    <= pwm_d;
      end
    end

    assign d_vec[i] = pwm_q;
  end

  assign cnt0_now = g_chan[0].cnt_q;

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign d0           = d_vec[0];
  assign d1           = d_vec[1];
  assign d2           = d_vec[2];
  assign d3           = d_vec[3];
  assign pending      = pending_q;
  assign upd_ack      = upd_ack_q;
  assign period_start = period_start_q;

endmodule
`default_nettype wire

// File: tb/tb_rgbw_pwm_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgbw_pwm_engine
// Purpose  : Directed self-checking bench for rgbw_pwm_engine (TOP=254,
//            PHASE_STEP=64). Expected values are hand-derived from the
//            counter arithmetic; a period is 255 ticks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgbw_pwm_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_half;
  logic       load;
  logic [7:0] duty0, duty1, duty2, duty3;
  logic       d0, d1, d2, d3;
  logic       pending, upd_ack, period_start;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rgbw_pwm_engine #(
    .TOP        (254),
    .PHASE_STEP (64)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .clk_half     (clk_half),
    .load         (load),
    .duty0        (duty0),
    .duty1        (duty1),
    .duty2        (duty2),
    .duty3        (duty3),
    .d0           (d0),
    .d1           (d1),
    .d2           (d2),
    .d3           (d3),
    .pending      (pending),
    .upd_ack      (upd_ack),
    .period_start (period_start)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given enables; outputs are observed 1ns later.
  task automatic tick(input logic h, input logic ld);
    clk_half = h;
    load     = ld;
    @(posedge clk);
    #1;
    clk_half = 1'b0;
    load     = 1'b0;
  endtask

  // n enabled ticks, counting high samples per output and upd_ack pulses.
  task automatic run_count(input int n, output int c0, output int c1,
                           output int c2, output int c3, output int acks);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0; acks = 0;
    for (int k = 0; k < n; k++) begin
      tick(1'b1, 1'b0);
      c0 += int'(d0); c1 += int'(d1); c2 += int'(d2); c3 += int'(d3);
      acks += int'(upd_ack);
    end
  endtask

  // Enabled ticks until upd_ack is seen; n is the number of ticks taken.
  task automatic wait_ack(output int n, output int ok);
    n  = 0;
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      tick(1'b1, 1'b0);
      n++;
      if (upd_ack) begin
        ok = 1;
        break;
      end
    end
  endtask

  initial begin
    int c0, c1, c2, c3, acks, n, ok;
    int rise [4];
    logic [3:0] prev, cur;
    int ps_first, ps_second, found;

    reset = 1'b0; clk_half = 1'b0; load = 1'b0;
    duty0 = 8'd0; duty1 = 8'd0; duty2 = 8'd0; duty3 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d",            int'({d3, d2, d1, d0}), 0);
    check("rst_pending",      int'(pending), 0);
    check("rst_upd_ack",      int'(upd_ack), 0);
    check("rst_period_start", int'(period_start), 0);
    reset = 1'b1;

    // ---- Duties 0/255/128/64 applied at the first wrap --------------------
    duty0 = 8'd0; duty1 = 8'd255; duty2 = 8'd128; duty3 = 8'd64;
    tick(1'b1, 1'b1);                       // cnt0 -> 1
    check("t1_pending_set", int'(pending), 1);
    run_count(253, c0, c1, c2, c3, acks);   // cnt0 -> 254
    check("t1_no_early_ack", acks, 0);
    tick(1'b1, 1'b0);                       // wrap edge
    check("t1_upd_ack",      int'(upd_ack), 1);
    check("t1_pending_clr",  int'(pending), 0);
    check("t1_period_start", int'(period_start), 1);
    run_count(255, c0, c1, c2, c3, acks);
    check("t1_d0_high", c0, 0);
    check("t1_d1_high", c1, 255);
    check("t1_d2_high", c2, 128);
    check("t1_d3_high", c3, 64);
    check("t1_single_ack", acks, 0);

    // ---- Phase stagger, all duties 64 -------------------------------------
    // Channel i goes high when its counter wraps to 0, i.e. when cnt0 has
    // reached 255 - 64*i; counting ticks from the update edge gives
    // rises at tick 1, 192, 128 and 64.
    duty0 = 8'd64; duty1 = 8'd64; duty2 = 8'd64; duty3 = 8'd64;
    tick(1'b1, 1'b1);                       // cnt0 -> 1
    wait_ack(n, ok);
    check("t2_ack_seen",  ok, 1);
    check("t2_ack_ticks", n, 254);
    for (int ch = 0; ch < 4; ch++) rise[ch] = 0;
    prev = {d3, d2, d1, d0};
    for (int t = 1; t <= 255; t++) begin
      tick(1'b1, 1'b0);
      cur = {d3, d2, d1, d0};
      for (int ch = 0; ch < 4; ch++) begin
        if (cur[ch] && !prev[ch] && rise[ch] == 0) rise[ch] = t;
      end
      prev = cur;
    end
    check("t2_rise_d0", rise[0], 1);
    check("t2_rise_d1", rise[1], 192);
    check("t2_rise_d2", rise[2], 128);
    check("t2_rise_d3", rise[3], 64);

    // ---- Two loads in one period: last wins, one ack ----------------------
    duty0 = 8'd100;
    tick(1'b1, 1'b1);                       // cnt0 -> 1
    repeat (10) tick(1'b1, 1'b0);           // cnt0 -> 11
    duty0 = 8'd200;
    tick(1'b1, 1'b1);                       // cnt0 -> 12
    check("t3_pending", int'(pending), 1);
    wait_ack(n, ok);
    check("t3_ack_seen",  ok, 1);
    check("t3_ack_ticks", n, 243);
    check("t3_pending_clr", int'(pending), 0);
    run_count(255, c0, c1, c2, c3, acks);
    check("t3_d0_high_200", c0, 200);
    check("t3_no_second_ack", acks, 0);

    // ---- Load in the exact wrap cycle while already pending ---------------
    duty0 = 8'd50;
    tick(1'b1, 1'b1);                       // cnt0 -> 1
    run_count(253, c0, c1, c2, c3, acks);   // cnt0 -> 254
    duty0 = 8'd80;
    tick(1'b1, 1'b1);                       // wrap edge with load
    check("t4_wrap_ack",     int'(upd_ack), 1);
    check("t4_still_pending", int'(pending), 1);
    run_count(255, c0, c1, c2, c3, acks);
    check("t4_d0_high_50", c0, 50);
    check("t4_second_ack", acks, 1);
    check("t4_pending_clr", int'(pending), 0);
    run_count(255, c0, c1, c2, c3, acks);
    check("t4_d0_high_80", c0, 80);

    // ---- Load at wrap with nothing pending --------------------------------
    run_count(254, c0, c1, c2, c3, acks);   // cnt0 -> 254
    duty0 = 8'd30;
    tick(1'b1, 1'b1);
    check("t5_no_ack",       int'(upd_ack), 0);
    check("t5_pending_set",  int'(pending), 1);
    check("t5_period_start", int'(period_start), 1);

    // ---- clk_half every 4th clock: 1020-cycle periods ---------------------
    ps_first = -1; ps_second = -1; found = 0;
    for (int i = 0; i < 2400 && found < 2; i++) begin
      tick((i % 4) == 0, 1'b0);
      if (period_start) begin
        if (found == 0) ps_first = i;
        else            ps_second = i;
        found++;
      end
    end
    check("t6_two_period_starts", found, 2);
    check("t6_period_spacing", ps_second - ps_first, 1020);

    // ---- Mid-period reset with d2 high and pending ------------------------
    found = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0);
      if (period_start) begin found = 1; break; end
    end
    check("t7_sync_period", found, 1);
    duty0 = 8'd10; duty1 = 8'd10; duty2 = 8'd10; duty3 = 8'd10;
    tick(1'b1, 1'b1);                       // cnt0 -> 1, pending
    found = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0);
      if (d2) begin found = 1; break; end
    end
    check("t7_d2_high", found, 1);
    check("t7_pending_before", int'(pending), 1);
    #2;
    reset = 1'b0;                           // away from any clock edge
    #1;
    check("t7_d2_async_low",   int'(d2), 0);
    check("t7_pending_async",  int'(pending), 0);
    reset = 1'b1;
    // Counters restart at 0/64/128/192: a load captured while frozen is
    // applied after exactly 255 ticks, when cnt2 moves 127 -> 128.
    duty0 = 8'd0; duty1 = 8'd0; duty2 = 8'd129; duty3 = 8'd0;
    tick(1'b0, 1'b1);
    check("t7_frozen_load", int'(pending), 1);
    wait_ack(n, ok);
    check("t7_ack_seen",  ok, 1);
    check("t7_ack_ticks", n, 255);
    tick(1'b1, 1'b0);
    check("t7_cnt2_at_128", int'(d2), 1);
    tick(1'b1, 1'b0);
    check("t7_cnt2_at_129", int'(d2), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
`default_nettype wire
